// File: rtl/axis_pkt_rr_arb.sv
// axis_pkt_rr_arb: packet-granular round-robin arbiter sharing one AXI-Stream
// egress among NUM_PORTS packet sources. A grant is held from the first beat
// through tlast. out_tid carries the source port of every beat.
// Optional per-port completed-packet counters: define AXIS_PKT_ARB_STATS_EN.
module axis_pkt_rr_arb #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_BYTES = 8,
  parameter int USER_WIDTH = 1,
  parameter int ID_W       = $clog2(NUM_PORTS)
) (
  input  logic                             clk,
  input  logic                             areset,
  input  logic [NUM_PORTS-1:0]             in_tvalid,
  output logic [NUM_PORTS-1:0]             in_tready,
  input  logic [NUM_PORTS*DATA_BYTES*8-1:0] in_tdata,
  input  logic [NUM_PORTS*DATA_BYTES-1:0]  in_tkeep,
  input  logic [NUM_PORTS-1:0]             in_tlast,
  input  logic [NUM_PORTS*USER_WIDTH-1:0]  in_tuser,
  output logic                             out_tvalid,
  input  logic                             out_tready,
  output logic [DATA_BYTES*8-1:0]          out_tdata,
  output logic [DATA_BYTES-1:0]            out_tkeep,
  output logic                             out_tlast,
  output logic [USER_WIDTH-1:0]            out_tuser,
  output logic [ID_W-1:0]                  out_tid,
  output logic                             grant_active,
  output logic [ID_W-1:0]                  grant_idx
`ifdef AXIS_PKT_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]          pkt_cnt
`endif
);

  localparam int DW = DATA_BYTES * 8;

  typedef enum logic {IDLE, LOCK} state_t;

  state_t                state;
  logic [ID_W-1:0]       last_grant;
  logic [ID_W-1:0]       next_grant;
  logic [ID_W-1:0]       cand;
  logic                  found;
  logic                  accept;
  logic                  skid_full;

  logic [DW-1:0]         sel_data;
  logic [DATA_BYTES-1:0] sel_keep;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  sel_last;

  logic [DW-1:0]         skid_data;
  logic [DATA_BYTES-1:0] skid_keep;
  logic [USER_WIDTH-1:0] skid_user;
  logic                  skid_last;
  logic [ID_W-1:0]       skid_tid;

  // Round-robin pick: first requesting port after last_grant, with wrap-around
  always_comb begin
    found      = 1'b0;
    next_grant = grant_idx;
    cand       = '0;
    for (int unsigned i = 1; i <= NUM_PORTS; i++) begin
      cand = ID_W'((32'(last_grant) + i) % NUM_PORTS);
      if (!found && in_tvalid[cand]) begin
        found      = 1'b1;
        next_grant = cand;
      end
    end
  end

  // Mux the granted port's beat and decide whether it is accepted this cycle
  always_comb begin
    sel_data = in_tdata[32'(grant_idx) * DW +: DW];
    sel_keep = in_tkeep[32'(grant_idx) * DATA_BYTES +: DATA_BYTES];
    sel_user = in_tuser[32'(grant_idx) * USER_WIDTH +: USER_WIDTH];
    sel_last = in_tlast[grant_idx];
    accept   = (state == LOCK) && in_tvalid[grant_idx] && !skid_full;
  end

  // Only the granted port sees ready, and only while the skid entry is free
  always_comb begin
    in_tready = '0;
    if (state == LOCK && !skid_full) in_tready[grant_idx] = 1'b1;
  end

  // Arbitration FSM: one IDLE cycle to pick, LOCK until the tlast beat is taken
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state        <= IDLE;
      grant_idx    <= '0;
      last_grant   <= ID_W'(NUM_PORTS - 1);
      grant_active <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            grant_idx    <= next_grant;
            grant_active <= 1'b1;
            state        <= LOCK;
          end
        end
        LOCK: begin
          if (accept && sel_last) begin
            last_grant   <= grant_idx;
            grant_active <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry output stage: main register drives out_*, skid catches the beat
  // accepted while main is stalled; skid always drains into main first.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      out_tvalid <= 1'b0;
      out_tdata  <= '0;
      out_tkeep  <= '0;
      out_tlast  <= 1'b0;
      out_tuser  <= '0;
      out_tid    <= '0;
      skid_full  <= 1'b0;
      skid_data  <= '0;
      skid_keep  <= '0;
      skid_last  <= 1'b0;
      skid_user  <= '0;
      skid_tid   <= '0;
    end else if (!out_tvalid || out_tready) begin
      if (skid_full) begin
        out_tvalid <= 1'b1;
        out_tdata  <= skid_data;
        out_tkeep  <= skid_keep;
        out_tlast  <= skid_last;
        out_tuser  <= skid_user;
        out_tid    <= skid_tid;
        skid_full  <= 1'b0;
      end else if (accept) begin
        out_tvalid <= 1'b1;
        out_tdata  <= sel_data;
        out_tkeep  <= sel_keep;
        out_tlast  <= sel_last;
        out_tuser  <= sel_user;
        out_tid    <= grant_idx;
      end else begin
        out_tvalid <= 1'b0;
      end
    end else if (accept) begin
      skid_full <= 1'b1;
      skid_data <= sel_data;
      skid_keep <= sel_keep;
      skid_last <= sel_last;
      skid_user <= sel_user;
      skid_tid  <= grant_idx;
    end
  end

`ifdef AXIS_PKT_ARB_STATS_EN
  // Count completed packets per source port, wrapping modulo 2^32
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      pkt_cnt <= '0;
    end else begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (accept && sel_last && grant_idx == ID_W'(p))
          pkt_cnt[p*32 +: 32] <= pkt_cnt[p*32 +: 32] + 32'd1;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_axis_pkt_rr_arb.sv
// Self-checking bench for axis_pkt_rr_arb (4 ports, 8-byte data, 1-bit user).
// Reference: per-port source queues, a global expected-beat FIFO, a beat
// occupancy count for the two-entry output stage and the round-robin rule.
module tb_axis_pkt_rr_arb;

  logic         clk = 1'b0;
  logic         areset;
  logic [3:0]   in_tvalid;
  logic [3:0]   in_tready;
  logic [255:0] in_tdata;
  logic [31:0]  in_tkeep;
  logic [3:0]   in_tlast;
  logic [3:0]   in_tuser;
  logic         out_tvalid;
  logic         out_tready;
  logic [63:0]  out_tdata;
  logic [7:0]   out_tkeep;
  logic         out_tlast;
  logic [0:0]   out_tuser;
  logic [1:0]   out_tid;
  logic         grant_active;
  logic [1:0]   grant_idx;
`ifdef AXIS_PKT_ARB_STATS_EN
  logic [127:0] pkt_cnt;
`endif

  axis_pkt_rr_arb #(
    .NUM_PORTS(4),
    .DATA_BYTES(8),
    .USER_WIDTH(1)
  ) dut (
    .clk(clk),
    .areset(areset),
    .in_tvalid(in_tvalid),
    .in_tready(in_tready),
    .in_tdata(in_tdata),
    .in_tkeep(in_tkeep),
    .in_tlast(in_tlast),
    .in_tuser(in_tuser),
    .out_tvalid(out_tvalid),
    .out_tready(out_tready),
    .out_tdata(out_tdata),
    .out_tkeep(out_tkeep),
    .out_tlast(out_tlast),
    .out_tuser(out_tuser),
    .out_tid(out_tid),
    .grant_active(grant_active),
    .grant_idx(grant_idx)
`ifdef AXIS_PKT_ARB_STATS_EN
    ,
    .pkt_cnt(pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        user;
    logic        last;
  } beat_t;

  typedef struct {
    beat_t      b;
    logic [1:0] tid;
  } sb_t;

  beat_t       srcq[4][$];
  sb_t         sbq[$];
  int          tid_log[$];
  int unsigned hold[4];

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned n_out    = 0;
  int unsigned last_acc_cyc = 0;
  bit          rdy_rand = 0;
  bit          rnd_hold = 0;

  // reference state
  bit          m_locked;
  int unsigned m_owner;
  int unsigned m_last;
  int unsigned m_gidx;
  int unsigned m_count;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int unsigned rr_pick(input int unsigned last, input logic [3:0] v);
    for (int unsigned i = 1; i <= 4; i++) begin
      if (v[(last + i) % 4]) return (last + i) % 4;
    end
    return 0;
  endfunction

  function automatic bit all_empty();
    for (int p = 0; p < 4; p++) if (srcq[p].size() != 0) return 0;
    return 1;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 4; p++) begin
      srcq[p].delete();
      hold[p] = 0;
    end
    sbq.delete();
    m_locked = 0;
    m_owner  = 0;
    m_last   = 3;
    m_gidx   = 0;
    m_count  = 0;
  endtask

  task automatic add_pkt(input int p, input int unsigned n);
    beat_t b;
    for (int unsigned i = 0; i < n; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = 8'($urandom);
      b.user = 1'($urandom);
      b.last = (i == n - 1);
      srcq[p].push_back(b);
    end
  endtask

  // One clock: drive, check against reference, clock, advance reference.
  task automatic step();
    logic [3:0]  exp_rdy;
    bit          acc, pop, arb;
    int unsigned nw;
    beat_t       b;
    sb_t         s;
    nw = 0;
    for (int p = 0; p < 4; p++) begin
      if (rnd_hold && hold[p] == 0 && $urandom_range(0, 4) == 0)
        hold[p] = $urandom_range(1, 3);
      if (srcq[p].size() > 0 && hold[p] == 0) begin
        b = srcq[p][0];
        in_tvalid[p]            = 1'b1;
        in_tdata[p*64 +: 64]    = b.data;
        in_tkeep[p*8 +: 8]      = b.keep;
        in_tuser[p]             = b.user;
        in_tlast[p]             = b.last;
      end else begin
        in_tvalid[p]            = 1'b0;
        in_tdata[p*64 +: 64]    = {$urandom, $urandom};
        in_tlast[p]             = 1'($urandom);
      end
    end
    out_tready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #2;
    exp_rdy = '0;
    if (m_locked && m_count < 2) exp_rdy[m_owner] = 1'b1;
    chk("in_tready", 64'(in_tready), 64'(exp_rdy));
    chk("out_tvalid", 64'(out_tvalid), 64'(m_count > 0));
    chk("grant_active", 64'(grant_active), 64'(m_locked));
    chk("grant_idx", 64'(grant_idx), 64'(m_gidx));
    if (m_count > 0 && sbq.size() > 0) begin
      chk("out_tdata", out_tdata, sbq[0].b.data);
      chk("out_tkeep", 64'(out_tkeep), 64'(sbq[0].b.keep));
      chk("out_tuser", 64'(out_tuser), 64'(sbq[0].b.user));
      chk("out_tlast", 64'(out_tlast), 64'(sbq[0].b.last));
      chk("out_tid", 64'(out_tid), 64'(sbq[0].tid));
    end
    acc = m_locked && m_count < 2 && in_tvalid[m_owner];
    pop = (m_count > 0) && out_tready;
    arb = !m_locked && (in_tvalid != 4'b0);
    if (arb) nw = rr_pick(m_last, in_tvalid);
    @(posedge clk);
    #1;
    for (int p = 0; p < 4; p++) if (hold[p] > 0) hold[p]--;
    if (pop && sbq.size() > 0) begin
      s = sbq.pop_front();
      n_out++;
      if (s.b.last) tid_log.push_back(int'(s.tid));
    end
    if (acc) begin
      b     = srcq[m_owner].pop_front();
      s.b   = b;
      s.tid = 2'(m_owner);
      sbq.push_back(s);
      if (b.last) begin
        m_locked     = 0;
        m_last       = m_owner;
        last_acc_cyc = cyc;
      end
    end
    m_count = m_count + 32'(acc) - 32'(pop);
    if (arb) begin
      m_locked = 1;
      m_owner  = nw;
      m_gidx   = nw;
    end
    cyc++;
  endtask

  task automatic run(input int unsigned budget);
    int unsigned n;
    bit done;
    n = 0;
    while (!(all_empty() && m_count == 0 && !m_locked) && n < budget) begin
      step();
      n++;
    end
    done = all_empty() && m_count == 0 && !m_locked;
    chk("drain_within_budget", 64'(done), 64'd1);
  endtask

  task automatic chk_tids(input string tag, input int exp[$]);
    chk({tag, "_count"}, 64'(tid_log.size()), 64'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(tag, (i < tid_log.size()) ? 64'(tid_log[i]) : 64'hDEAD, 64'(exp[i]));
  endtask

  initial begin
    int unsigned start;
    int unsigned guard;
`ifdef AXIS_PKT_ARB_STATS_EN
    logic [127:0] cnt0;
`endif
    areset     = 1'b1;
    in_tvalid  = '0;
    in_tdata   = '0;
    in_tkeep   = '0;
    in_tlast   = '0;
    in_tuser   = '0;
    out_tready = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_in_tready", 64'(in_tready), 64'd0);
    chk("rst_grant_active", 64'(grant_active), 64'd0);
    chk("rst_grant_idx", 64'(grant_idx), 64'd0);
    chk("rst_out_tdata", out_tdata, 64'd0);
    chk("rst_out_tid", 64'(out_tid), 64'd0);
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;

    // All four ports present a 3-beat packet at once
    tid_log.delete();
    for (int p = 0; p < 4; p++) add_pkt(p, 3);
    start = cyc;
    run(100);
    chk_tids("t1_order", '{0, 1, 2, 3});
    chk("t1_last_beat_cycle", 64'(last_acc_cyc - start + 1), 64'd16);

    // Port 1 back-to-back 2-beat packets against port 2
    tid_log.delete();
    for (int i = 0; i < 3; i++) add_pkt(1, 2);
    for (int i = 0; i < 2; i++) add_pkt(2, 2);
    run(100);
    chk_tids("t2_order", '{1, 2, 1, 2, 1});

    // 8-beat packet under random backpressure
    tid_log.delete();
    n_out = 0;
    rdy_rand = 1;
    add_pkt(0, 8);
    run(200);
    rdy_rand = 0;
    chk("t3_beats_out", 64'(n_out), 64'd8);
    chk_tids("t3_order", '{0});

    // Granted port stalls mid-packet while port 3 waits
    tid_log.delete();
    add_pkt(1, 6);
    add_pkt(3, 2);
    guard = 0;
    while (srcq[1].size() > 4 && guard < 50) begin
      step();
      guard++;
    end
    chk("t4_reached_stall_point", 64'(srcq[1].size()), 64'd4);
    hold[1] = 5;
    run(100);
    chk_tids("t4_order", '{1, 3});

    // Reset in the middle of a packet
    add_pkt(0, 1);
    run(50);
    add_pkt(2, 4);
    guard = 0;
    while (srcq[2].size() > 2 && guard < 50) begin
      step();
      guard++;
    end
    chk("t5_reached_beat2", 64'(srcq[2].size()), 64'd2);
    areset = 1'b1;
    #1;
    chk("t5_rst_out_tvalid", 64'(out_tvalid), 64'd0);
    chk("t5_rst_in_tready", 64'(in_tready), 64'd0);
    chk("t5_rst_grant_active", 64'(grant_active), 64'd0);
    in_tvalid = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;
    tid_log.delete();
    add_pkt(1, 2);
    add_pkt(0, 2);
    run(100);
    chk_tids("t5_order_after_reset", '{0, 1});

    // Mixed random traffic with random stalls and backpressure
    rdy_rand = 1;
    rnd_hold = 1;
    for (int i = 0; i < 30; i++) add_pkt($urandom_range(0, 3), $urandom_range(1, 5));
    run(3000);
    rdy_rand = 0;
    rnd_hold = 0;
    for (int p = 0; p < 4; p++) hold[p] = 0;

`ifdef AXIS_PKT_ARB_STATS_EN
    cnt0 = pkt_cnt;
    for (int i = 0; i < 5; i++) add_pkt(2, $urandom_range(1, 3));
    add_pkt(0, 2);
    run(200);
    chk("stats_port0", 64'(pkt_cnt[0 +: 32] - cnt0[0 +: 32]), 64'd1);
    chk("stats_port1", 64'(pkt_cnt[32 +: 32] - cnt0[32 +: 32]), 64'd0);
    chk("stats_port2", 64'(pkt_cnt[64 +: 32] - cnt0[64 +: 32]), 64'd5);
    chk("stats_port3", 64'(pkt_cnt[96 +: 32] - cnt0[96 +: 32]), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
